// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared byte-wide transaction bus.
// The winning master's command word is latched and sent low byte first
// (opcode, then address bytes) under a valid/ready handshake.
//
// state | meaning
// IDLE  | no transaction; arbitrate between pending requests
// SEND  | word latched, streaming bytes to the bus controller
module bus_arbiter #(
    parameter int ADDRW = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sha_req,
    input  logic             aes_req,
    input  logic [ADDRW+7:0] sha_data_in,
    input  logic [ADDRW+7:0] aes_data_in,
    input  logic             bus_ready,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             aes_grant,
    output logic             sha_grant
);

    localparam int W  = ADDRW + 8;
    localparam int NB = W / 8;
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic [CW-1:0]   r_cnt;
    logic            r_last_aes;
    logic            r_valid;
    logic            r_aes_grant;
    logic            r_sha_grant;

    logic            w_any_req;
    logic            w_aes_wins;
    logic [W-1:0]    w_win_word;
    logic            w_xfer;

    // AES wins when it is the only requester, or on a tie when SHA was served last.
    assign w_any_req  = aes_req | sha_req;
    assign w_aes_wins = aes_req & (~sha_req | ~r_last_aes);
    assign w_win_word = w_aes_wins ? aes_data_in : sha_data_in;
    assign w_xfer     = r_valid & bus_ready;

    // Arbitration and byte serialization; the low byte of the shift register is the bus byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_last_aes  <= 1'b0;
            r_valid     <= 1'b0;
            r_aes_grant <= 1'b0;
            r_sha_grant <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state     <= SEND;
                        r_shift     <= w_win_word;
                        r_cnt       <= '0;
                        r_valid     <= 1'b1;
                        r_aes_grant <= w_aes_wins;
                        r_sha_grant <= ~w_aes_wins;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state     <= IDLE;
                            r_shift     <= '0;
                            r_cnt       <= '0;
                            r_valid     <= 1'b0;
                            r_last_aes  <= r_aes_grant;
                            r_aes_grant <= 1'b0;
                            r_sha_grant <= 1'b0;
                        end else begin
                            r_shift <= r_shift >> 8;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_shift     <= '0;
                    r_cnt       <= '0;
                    r_valid     <= 1'b0;
                    r_aes_grant <= 1'b0;
                    r_sha_grant <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = r_shift[7:0];
    assign valid_out = r_valid;
    assign aes_grant = r_aes_grant;
    assign sha_grant = r_sha_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single grant, round-robin,
// stalls, word latching, mid-transaction reset and grant exclusivity.
module tb_bus_arbiter;

    localparam int ADDRW = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sha_req = 1'b0;
    logic        aes_req = 1'b0;
    logic [31:0] sha_data_in = '0;
    logic [31:0] aes_data_in = '0;
    logic        bus_ready = 1'b0;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        aes_grant;
    logic        sha_grant;

    int n_checks = 0;
    int n_errors = 0;

    // 100 MHz system clock
    always #5 clk = ~clk;

    bus_arbiter #(.ADDRW(ADDRW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sha_req     (sha_req),
        .aes_req     (aes_req),
        .sha_data_in (sha_data_in),
        .aes_data_in (aes_data_in),
        .bus_ready   (bus_ready),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .aes_grant   (aes_grant),
        .sha_grant   (sha_grant)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
        return w[8*k +: 8];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL reset_async: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
        tick();
        tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL reset_held: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
    endtask

    task automatic test_single_aes();
        logic [31:0] w;
        w = 32'hDEADBE01;
        aes_data_in = w;
        aes_req = 1'b1;
        bus_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b110, byte_at(w, k)}) begin
                n_errors++;
                $display("FAIL single_aes_byte%0d: got %h expected %h", k,
                         {valid_out, aes_grant, sha_grant, data_out}, {3'b110, byte_at(w, k)});
            end
            if (k == 0) aes_req = 1'b0;
            tick();
        end
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL single_aes_end: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] wa;
        logic [31:0] ws;
        wa = 32'hAABBCC55;
        ws = 32'h11223344;
        do_reset();
        aes_data_in = wa;
        sha_data_in = ws;
        aes_req = 1'b1;
        sha_req = 1'b1;
        bus_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b110, byte_at(wa, k)}) begin
                n_errors++;
                $display("FAIL rr_aes_byte%0d: got %h expected %h", k,
                         {valid_out, aes_grant, sha_grant, data_out}, {3'b110, byte_at(wa, k)});
            end
            if (k == 0) aes_req = 1'b0;
            tick();
        end
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL rr_idle_gap: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b101, byte_at(ws, k)}) begin
                n_errors++;
                $display("FAIL rr_sha_byte%0d: got %h expected %h", k,
                         {valid_out, aes_grant, sha_grant, data_out}, {3'b101, byte_at(ws, k)});
            end
            if (k == 0) sha_req = 1'b0;
            tick();
        end
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL rr_sha_end: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
        aes_req = 1'b1;
        sha_req = 1'b1;
        tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b110, byte_at(wa, 0)}) begin
            n_errors++;
            $display("FAIL rr_third_aes: got %h expected %h",
                     {valid_out, aes_grant, sha_grant, data_out}, {3'b110, byte_at(wa, 0)});
        end
        aes_req = 1'b0;
        sha_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL rr_third_end: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        int          pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int          idx;
        w = 32'hC0FFEE5A;
        sha_data_in = w;
        sha_req = 1'b1;
        bus_ready = 1'b0;
        tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b101, byte_at(w, 0)}) begin
            n_errors++;
            $display("FAIL stall_grant: got %h expected %h",
                     {valid_out, aes_grant, sha_grant, data_out}, {3'b101, byte_at(w, 0)});
        end
        sha_req = 1'b0;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            bus_ready = pat[i][0];
            tick();
            if (pat[i] != 0) idx++;
            n_checks++;
            if (idx < 4) begin
                if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b101, byte_at(w, idx)}) begin
                    n_errors++;
                    $display("FAIL stall_cycle%0d: got %h expected %h", i,
                             {valid_out, aes_grant, sha_grant, data_out}, {3'b101, byte_at(w, idx)});
                end
            end else begin
                if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
                    n_errors++;
                    $display("FAIL stall_cycle%0d: got %h expected %h", i,
                             {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
                end
            end
        end
    endtask

    task automatic test_latch();
        logic [31:0] w;
        w = 32'h87654321;
        sha_data_in = w;
        sha_req = 1'b1;
        bus_ready = 1'b1;
        tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b101, byte_at(w, 0)}) begin
            n_errors++;
            $display("FAIL latch_grant: got %h expected %h",
                     {valid_out, aes_grant, sha_grant, data_out}, {3'b101, byte_at(w, 0)});
        end
        sha_req = 1'b0;
        sha_data_in = '0;
        for (int k = 1; k < 4; k++) begin
            tick();
            n_checks++;
            if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b101, byte_at(w, k)}) begin
                n_errors++;
                $display("FAIL latch_byte%0d: got %h expected %h", k,
                         {valid_out, aes_grant, sha_grant, data_out}, {3'b101, byte_at(w, k)});
            end
        end
        tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL latch_end: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        w = 32'h0BADF00D;
        aes_data_in = w;
        aes_req = 1'b1;
        bus_ready = 1'b1;
        tick();
        aes_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== {3'b110, byte_at(w, 2)}) begin
            n_errors++;
            $display("FAIL rstmid_before: got %h expected %h",
                     {valid_out, aes_grant, sha_grant, data_out}, {3'b110, byte_at(w, 2)});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
            n_errors++;
            $display("FAIL rstmid_async: got %h expected %h", {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({valid_out, aes_grant, sha_grant, data_out} !== 11'h0) begin
                n_errors++;
                $display("FAIL rstmid_after%0d: got %h expected %h", i,
                         {valid_out, aes_grant, sha_grant, data_out}, 11'h0);
            end
        end
    endtask

    task automatic test_exclusive();
        for (int i = 0; i < 300; i++) begin
            sha_req     = 1'($urandom_range(0, 1));
            aes_req     = 1'($urandom_range(0, 1));
            bus_ready   = 1'($urandom_range(0, 1));
            sha_data_in = $urandom;
            aes_data_in = $urandom;
            tick();
            n_checks++;
            if ((aes_grant & sha_grant) !== 1'b0 || valid_out !== (aes_grant ^ sha_grant)) begin
                n_errors++;
                $display("FAIL exclusive_cycle%0d: got valid=%b aes=%b sha=%b expected one grant iff valid",
                         i, valid_out, aes_grant, sha_grant);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_aes();
        test_round_robin();
        test_stall();
        test_latch();
        test_reset_mid();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the shared byte-wide transaction bus between the SHA and AES cores and the memory/bus controller.
- Each master presents an (ADDRW+8)-bit command word: 8-bit opcode in the low byte, address above it.
- The arbiter grants one master at a time and latches its word.
- It serializes the word byte-by-byte onto data_out under a valid/ready handshake.

Parameters:
- ADDRW, 24, address width in bits. Must be a multiple of 8 and ≥ 8. Word width W = ADDRW+8; bytes per transaction NB = W/8 (4 at default).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- sha_req  input  1  SHA requests a bus transaction
- aes_req  input  1  AES requests a bus transaction
- sha_data_in  input  ADDRW+8  SHA command word, [7:0] opcode, [ADDRW+7:8] address
- aes_data_in  input  ADDRW+8  AES command word, same layout
- bus_ready  input  1  downstream accepts the current byte this cycle
- data_out  output  8  current byte of the granted word
- valid_out  output  1  data_out holds a valid byte
- aes_grant  output  1  AES owns the bus for the current transaction
- sha_grant  output  1  SHA owns the bus for the current transaction

Behaviour:
- Reset:
  - Asynchronous on rst_n low.
  - data_out=0, valid_out=0, aes_grant=0, sha_grant=0, state=IDLE, byte count=0, last-served=SHA (so AES wins the first tie).
- Outputs: all registered; aes_grant and sha_grant are never both 1.
- State IDLE:
  - valid_out=0, grants=0.
  - On a clock edge with any request, choose the winner:
    - Only one request: that master wins.
    - Both requesting: the master NOT served last wins (round-robin).
  - Next cycle: winner's grant=1; its data_in captured into an internal W-bit shift register; data_out=data_in[7:0]; valid_out=1; state=SEND; byte count=0.
  - Latency from req sampled high in IDLE to first valid byte: 1 cycle.
- State SEND:
  - A byte transfers on a clock edge where valid_out=1 and bus_ready=1.
  - On a transfer that is not the last byte: shift the register right by 8, data_out takes the next byte, count increments. Byte k = latched_word[8k+7:8k], k=0..NB-1, low byte (opcode) first.
  - bus_ready=0: data_out, valid_out and count hold; stalls are unlimited.
  - Transfer of byte NB-1: next cycle valid_out=0, grant cleared, data_out=0, last-served=current master, state=IDLE.
  - There is at least one idle cycle between consecutive transactions. Arbitration happens only in IDLE.
- Request rules:
  - A master holds req until it sees its grant.
  - Deasserting req after grant does not abort; the full word is still sent.
  - Changes to data_in after grant are ignored because the word is latched.
  - A req dropped before grant produces no transaction.
  - A master still requesting at end of its transaction may win again if the other master is not requesting.
- bus_ready is ignored while valid_out=0.
- Reset asserted mid-transaction: immediate return to reset values; the partial word is discarded and not resumed.

Test Plan:
- Reset, then aes_req=1, aes_data_in=32'hDEADBE01, bus_ready=1 -> 1 cycle later aes_grant=1, valid_out=1, data_out 01,BE,AD,DE on 4 consecutive cycles, then valid_out=0, aes_grant=0.
- Both requests after reset, sha_data_in=32'h11223344, aes_data_in=32'hAABBCC55 -> AES served first (55,CC,BB,AA); SHA granted after the idle cycle (44,33,22,11); a third simultaneous request goes to AES again.
- SHA transaction with bus_ready toggled 1,0,0,1,1,0,1 -> data_out/valid_out held during low cycles; exactly 4 bytes accepted in order; sha_grant stays 1 throughout.
- Grant SHA, then drop sha_req and change sha_data_in to 0 in the next cycle -> original 4 bytes still sent unchanged.
- Assert rst_n=0 after 2 bytes accepted -> outputs 0 immediately (asynchronous); after release with no req, valid_out stays 0.
- Grant-exclusivity check every cycle over random req/bus_ready traffic -> aes_grant & sha_grant never 1 together; valid_out=1 only when exactly one grant is 1.
